// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS MEM pipeline stage: data-memory access with configurable
//                latency (stalling upstream while busy), branch resolution and
//                the MEM/WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctlout,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        misalign,
    output logic [1:0]  mem_wb_ctl,
    output logic [31:0] mem_read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             CW         = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam int             C_INIT_I   = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [CW-1:0]  C_CNT_INIT = CW'(C_INIT_I);
    localparam bit             C_MULTI    = (MEM_LAT > 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_stall;
    logic            w_complete;
    logic            w_rw;
    logic            w_aligned;
    logic            w_acc;
    logic            w_misal;
    logic [AW-1:0]   w_idx;

    logic [31:0]     r_mem [DEPTH];

    logic            r_misalign;
    logic [1:0]      r_ctl;
    logic [31:0]     r_rdata;
    logic [31:0]     r_alu;
    logic [4:0]      r_wreg;

    assign w_rw      = memread | memwrite;
    assign w_aligned = (alu_result[1:0] == 2'b00);
    assign w_acc     = w_rw & w_aligned;
    assign w_misal   = w_rw & ~w_aligned;
    // Upper address bits are ignored so the word index wraps modulo DEPTH.
    assign w_idx     = alu_result[AW+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && C_MULTI) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = C_CNT_INIT;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset aborts an in-flight access, so stall releases immediately.
        if (rst) begin
            w_stall    = 1'b0;
            w_complete = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
            r_ctl      <= 2'b00;
            r_rdata    <= 32'h0;
            r_alu      <= 32'h0;
            r_wreg     <= 5'h0;
        end else if (w_stall) begin
            r_misalign <= 1'b0;
            r_ctl      <= 2'b00;
        end else if (w_misal) begin
            r_misalign <= 1'b1;
            r_ctl      <= 2'b00;
            r_rdata    <= 32'h0;
            r_alu      <= 32'h0;
            r_wreg     <= 5'h0;
        end else begin
            r_misalign <= 1'b0;
            r_ctl      <= wb_ctlout;
            r_alu      <= alu_result;
            r_wreg     <= five_bit_muxout;
            // A combined read+write performs only the write.
            r_rdata    <= (memread && !memwrite) ? r_mem[w_idx] : 32'h0;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_complete && w_acc && memwrite) begin
            r_mem[w_idx] <= rdata2out;
        end
    end

    assign pcsrc          = branch & zero;
    assign branch_target  = add_result;
    assign stall          = w_stall;
    assign misalign       = r_misalign;
    assign mem_wb_ctl     = r_ctl;
    assign mem_read_data  = r_rdata;
    assign mem_alu_result = r_alu;
    assign mem_write_reg  = r_wreg;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage at latencies 1, 3 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [3];
    logic [1:0]  wb    [3];
    logic        br    [3];
    logic        mrd   [3];
    logic        mwr   [3];
    logic [31:0] add   [3];
    logic        zr    [3];
    logic [31:0] alu   [3];
    logic [31:0] wd    [3];
    logic [4:0]  dst   [3];

    logic        pcsrc_o [3];
    logic [31:0] tgt_o   [3];
    logic        stall_o [3];
    logic        mis_o   [3];
    logic [1:0]  ctl_o   [3];
    logic [31:0] rdat_o  [3];
    logic [31:0] ralu_o  [3];
    logic [4:0]  rdst_o  [3];

    int total = 0;
    int bad   = 0;

    mem_stage #(.DEPTH(256), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst_s[0]), .wb_ctlout(wb[0]), .branch(br[0]),
        .memread(mrd[0]), .memwrite(mwr[0]), .add_result(add[0]), .zero(zr[0]),
        .alu_result(alu[0]), .rdata2out(wd[0]), .five_bit_muxout(dst[0]),
        .pcsrc(pcsrc_o[0]), .branch_target(tgt_o[0]), .stall(stall_o[0]),
        .misalign(mis_o[0]), .mem_wb_ctl(ctl_o[0]), .mem_read_data(rdat_o[0]),
        .mem_alu_result(ralu_o[0]), .mem_write_reg(rdst_o[0]));

    mem_stage #(.DEPTH(256), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst_s[1]), .wb_ctlout(wb[1]), .branch(br[1]),
        .memread(mrd[1]), .memwrite(mwr[1]), .add_result(add[1]), .zero(zr[1]),
        .alu_result(alu[1]), .rdata2out(wd[1]), .five_bit_muxout(dst[1]),
        .pcsrc(pcsrc_o[1]), .branch_target(tgt_o[1]), .stall(stall_o[1]),
        .misalign(mis_o[1]), .mem_wb_ctl(ctl_o[1]), .mem_read_data(rdat_o[1]),
        .mem_alu_result(ralu_o[1]), .mem_write_reg(rdst_o[1]));

    mem_stage #(.DEPTH(256), .MEM_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst_s[2]), .wb_ctlout(wb[2]), .branch(br[2]),
        .memread(mrd[2]), .memwrite(mwr[2]), .add_result(add[2]), .zero(zr[2]),
        .alu_result(alu[2]), .rdata2out(wd[2]), .five_bit_muxout(dst[2]),
        .pcsrc(pcsrc_o[2]), .branch_target(tgt_o[2]), .stall(stall_o[2]),
        .misalign(mis_o[2]), .mem_wb_ctl(ctl_o[2]), .mem_read_data(rdat_o[2]),
        .mem_alu_result(ralu_o[2]), .mem_write_reg(rdst_o[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory per instance plus the expected
    // MEM/WB contents, advanced once per rising edge.
    logic [31:0] mmem [3][256];
    logic [1:0]  e_ctl [3];
    logic [31:0] e_rd  [3];
    logic [31:0] e_alu [3];
    logic [4:0]  e_dst [3];
    logic        e_mis [3];
    int          age   [3];
    bit          armed = 1'b0;

    function automatic bit is_acc(input int k);
        return (mrd[k] || mwr[k]) && (alu[k][1:0] == 2'b00);
    endfunction

    function automatic bit exp_stall(input int k);
        return !rst_s[k] && is_acc(k) && (age[k] < lat_of(k) - 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [7:0] idx;
            idx = alu[k][9:2];
            if (rst_s[k]) begin
                e_ctl[k] = 2'b00; e_rd[k] = 32'h0; e_alu[k] = 32'h0;
                e_dst[k] = 5'h0;  e_mis[k] = 1'b0; age[k] = 0;
            end else if ((mrd[k] || mwr[k]) && alu[k][1:0] != 2'b00) begin
                e_ctl[k] = 2'b00; e_rd[k] = 32'h0; e_alu[k] = 32'h0;
                e_dst[k] = 5'h0;  e_mis[k] = 1'b1; age[k] = 0;
            end else if (exp_stall(k)) begin
                e_ctl[k] = 2'b00; e_mis[k] = 1'b0; age[k] = age[k] + 1;
            end else begin
                e_ctl[k] = wb[k]; e_alu[k] = alu[k]; e_dst[k] = dst[k]; e_mis[k] = 1'b0;
                e_rd[k]  = (mrd[k] && !mwr[k]) ? mmem[k][idx] : 32'h0;
                if (is_acc(k) && mwr[k]) mmem[k][idx] = wd[k];
                age[k] = 0;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("stall[%0d]", k), 32'(stall_o[k]), 32'(exp_stall(k)));
                chk($sformatf("pcsrc[%0d]", k), 32'(pcsrc_o[k]), 32'(br[k] & zr[k]));
                chk($sformatf("target[%0d]", k), tgt_o[k], add[k]);
                chk($sformatf("misalign[%0d]", k), 32'(mis_o[k]), 32'(e_mis[k]));
                chk($sformatf("wb_ctl[%0d]", k), 32'(ctl_o[k]), 32'(e_ctl[k]));
                chk($sformatf("rdata[%0d]", k), rdat_o[k], e_rd[k]);
                chk($sformatf("alu[%0d]", k), ralu_o[k], e_alu[k]);
                chk($sformatf("wreg[%0d]", k), 32'(rdst_o[k]), 32'(e_dst[k]));
            end
        end
    end

    task automatic set_idle(input int k);
        wb[k] = 2'b00; br[k] = 1'b0; mrd[k] = 1'b0; mwr[k] = 1'b0;
        add[k] = 32'h0; zr[k] = 1'b0; alu[k] = 32'h0; wd[k] = 32'h0; dst[k] = 5'h0;
    endtask

    // Presents one op, holds it until stall clears, returns after the
    // completion edge with idle inputs applied.
    task automatic issue(input int k, input logic [1:0] w, input logic r, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, output int nstall);
        logic [4:0] rd_reg;
        rd_reg = a[6:2] + 5'd1;
        wb[k] = w; mrd[k] = r; mwr[k] = wr; alu[k] = a; wd[k] = d; dst[k] = rd_reg;
        nstall = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!stall_o[k]) break;
            nstall++;
        end
        if (nstall >= 30) begin
            total++; bad++;
            $display("FAIL stall_timeout[%0d]: got stuck expected release", k);
        end
        @(posedge clk); #1;
        set_idle(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 256; j++) mmem[k][j] = 32'h0;
            rst_s[k] = 1'b1;
            set_idle(k);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        @(negedge clk);
        chk("reset_ctl", 32'(ctl_o[1]), 32'h0);
        chk("reset_rdata", rdat_o[2], 32'h0);
        @(posedge clk); #1;

        // Single-cycle latency: store then load.
        issue(0, 2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns);
        chk("lat1_store_stalls", 32'(ns), 32'd0);
        issue(0, 2'b11, 1'b1, 1'b0, 32'h10, 32'h0, ns);
        chk("lat1_load_stalls", 32'(ns), 32'd0);
        chk("lat1_load_data", rdat_o[0], 32'hDEADBEEF);
        chk("lat1_load_ctl", 32'(ctl_o[0]), 32'h3);

        // Three-cycle latency.
        issue(1, 2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns);
        chk("lat3_store_stalls", 32'(ns), 32'd2);
        issue(1, 2'b11, 1'b1, 1'b0, 32'h10, 32'h0, ns);
        chk("lat3_load_stalls", 32'(ns), 32'd2);
        chk("lat3_load_data", rdat_o[1], 32'hDEADBEEF);
        chk("lat3_load_ctl", 32'(ctl_o[1]), 32'h3);

        // Misaligned load is rejected as a bubble.
        issue(1, 2'b11, 1'b1, 1'b0, 32'h12, 32'h0, ns);
        chk("misal_stalls", 32'(ns), 32'd0);
        chk("misal_flag", 32'(mis_o[1]), 32'h1);
        chk("misal_ctl", 32'(ctl_o[1]), 32'h0);
        @(posedge clk); #1;
        chk("misal_clear", 32'(mis_o[1]), 32'h0);

        // Branch resolution.
        br[0] = 1'b1; zr[0] = 1'b1; add[0] = 32'h40;
        @(negedge clk);
        chk("branch_taken", 32'(pcsrc_o[0]), 32'h1);
        chk("branch_target", tgt_o[0], 32'h40);
        @(posedge clk); #1;
        zr[0] = 1'b0;
        @(negedge clk);
        chk("branch_not_taken", 32'(pcsrc_o[0]), 32'h0);
        @(posedge clk); #1;
        set_idle(0);

        // Combined read+write performs the write only.
        issue(0, 2'b10, 1'b1, 1'b1, 32'h30, 32'h55, ns);
        chk("rw_rdata", rdat_o[0], 32'h0);
        chk("rw_ctl", 32'(ctl_o[0]), 32'h2);
        issue(0, 2'b11, 1'b1, 1'b0, 32'h30, 32'h0, ns);
        chk("rw_readback", rdat_o[0], 32'h55);

        // Address wrap modulo DEPTH.
        issue(0, 2'b00, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, ns);
        issue(0, 2'b11, 1'b1, 1'b0, 32'h000, 32'h0, ns);
        chk("wrap_load", rdat_o[0], 32'hA5A5A5A5);

        // Reset during a busy store aborts it.
        issue(2, 2'b00, 1'b0, 1'b1, 32'h20, 32'h0, ns);
        chk("lat4_store_stalls", 32'(ns), 32'd3);
        wb[2] = 2'b00; mwr[2] = 1'b1; alu[2] = 32'h20; wd[2] = 32'h1234; dst[2] = 5'd9;
        @(posedge clk); #1;
        rst_s[2] = 1'b1;
        @(negedge clk);
        chk("abort_stall", 32'(stall_o[2]), 32'h0);
        @(posedge clk); #1;
        rst_s[2] = 1'b0;
        set_idle(2);
        @(negedge clk);
        chk("abort_ctl", 32'(ctl_o[2]), 32'h0);
        chk("abort_alu", ralu_o[2], 32'h0);
        @(posedge clk); #1;
        issue(2, 2'b11, 1'b1, 1'b0, 32'h20, 32'h0, ns);
        chk("abort_readback", rdat_o[2], 32'h0);
        chk("abort_read_ctl", 32'(ctl_o[2]), 32'h3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
